// File: rtl/arch_defs_pkg.sv
// Shared definitions for the up/down/bounce counter peripheral.
//   DATA_WIDTH      default width of count, limits and load value
//   UDC_* constants encoding of the mode input
//   counter_mode_t  operating mode
//   bounce_state_t  direction/dwell state used in BOUNCE mode
package arch_defs_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  localparam logic [1:0] UDC_UP_WRAP   = 2'd0;
  localparam logic [1:0] UDC_DOWN_WRAP = 2'd1;
  localparam logic [1:0] UDC_SATURATE  = 2'd2;
  localparam logic [1:0] UDC_BOUNCE    = 2'd3;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = UDC_UP_WRAP,
    MODE_DOWN_WRAP = UDC_DOWN_WRAP,
    MODE_SATURATE  = UDC_SATURATE,
    MODE_BOUNCE    = UDC_BOUNCE
  } counter_mode_t;

  typedef enum logic [1:0] {
    BS_UP       = 2'd0,
    BS_DOWN     = 2'd1,
    BS_DWELL_HI = 2'd2,
    BS_DWELL_LO = 2'd3
  } bounce_state_t;

endpackage

// File: rtl/udc_step_alu.sv
// Combinational step arithmetic for updown_bounce_counter.
// Ports:
//   count_i, step_i, lo_i, hi_i  current count, step and inclusive limits
//   load_val_i                   value to be clamped for a load
//   up_i                         1 = evaluate an upward step, 0 = downward
//   nxt_c_o                      count +/- step (valid only when !over_c_o)
//   over_c_o                     step would pass beyond the limit in the travel direction
//   reach_c_o                    step would reach or pass the limit
//   oor_c_o                      count lies outside [lo, hi]
//   clamp_cnt_c_o, clamp_ld_c_o  count / load_val clamped into [lo, hi]
module udc_step_alu
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_WIDTH,
  parameter int unsigned STEP_W = 4
) (
  input  logic [WIDTH-1:0]  count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic [WIDTH-1:0]  lo_i,
  input  logic [WIDTH-1:0]  hi_i,
  input  logic [WIDTH-1:0]  load_val_i,
  input  logic              up_i,
  output logic [WIDTH-1:0]  nxt_c_o,
  output logic              over_c_o,
  output logic              reach_c_o,
  output logic              oor_c_o,
  output logic [WIDTH-1:0]  clamp_cnt_c_o,
  output logic [WIDTH-1:0]  clamp_ld_c_o
);

  localparam int unsigned XW = WIDTH + 1;

  logic [XW-1:0]    cnt_x;
  logic [XW-1:0]    step_x;
  logic [XW-1:0]    lo_x;
  logic [XW-1:0]    hi_x;
  logic [XW-1:0]    sum_x;
  logic [XW-1:0]    lo_step_x;
  logic [WIDTH-1:0] diff;

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] lo,
                                             input logic [WIDTH-1:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Extra headroom bit keeps count+step and lo+step from aliasing.
  assign cnt_x     = XW'(count_i);
  assign step_x    = XW'(step_i);
  assign lo_x      = XW'(lo_i);
  assign hi_x      = XW'(hi_i);
  assign sum_x     = cnt_x + step_x;
  assign lo_step_x = lo_x + step_x;
  assign diff      = count_i - WIDTH'(step_i);

  assign nxt_c_o   = up_i ? sum_x[WIDTH-1:0] : diff;
  // Downward tests compare against lo+step so count-step never underflows.
  assign over_c_o  = up_i ? (sum_x > hi_x)  : (cnt_x < lo_step_x);
  assign reach_c_o = up_i ? (sum_x >= hi_x) : (cnt_x <= lo_step_x);
  assign oor_c_o   = (count_i < lo_i) || (count_i > hi_i);

  assign clamp_cnt_c_o = clamp(count_i, lo_i, hi_i);
  assign clamp_ld_c_o  = clamp(load_val_i, lo_i, hi_i);

endmodule

// File: rtl/updown_bounce_counter.sv
// Multi-mode up/down counter: wrap up, wrap down, saturate and bounce
// (ping-pong with optional dwell at each limit), runtime limits and step.
// Optional feature macro: UDC_CYCLE_COUNT_EN (adds target/cycles/done).
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   en, load, load_val  advance strobe, load strobe (wins over en), load value
//   mode, dir           counter_mode_t, direction for SATURATE (1 = up)
//   lo_lim, hi_lim      inclusive limits
//   step                increment per enabled cycle
//   count, dir_up       registered count and direction
//   turn                one-cycle pulse on wrap or bounce reversal
//   cfg_err             registered, high while lo_lim > hi_lim
//   target, cycles, done  (UDC_CYCLE_COUNT_EN only) cycle counting and stop
module updown_bounce_counter
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_WIDTH,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned DWELL     = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [1:0]        mode,
  input  logic              dir,
  input  logic [WIDTH-1:0]  lo_lim,
  input  logic [WIDTH-1:0]  hi_lim,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              dir_up,
  output logic              turn,
  output logic              cfg_err
`ifdef UDC_CYCLE_COUNT_EN
  ,
  input  logic [7:0]        target,
  output logic [7:0]        cycles,
  output logic              done
`endif
);

  localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = (DWELL > 0) ? DW_W'(DWELL - 1) : '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_up_q, dir_up_d;
  logic             turn_q, turn_d;
  logic             cfg_err_q;
  bounce_state_t    state_q, state_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;

  counter_mode_t    mode_c;
  logic             cfg_bad_c;
  logic             run_c;
  logic             alu_up_c;

  logic [WIDTH-1:0] nxt_c;
  logic             over_c;
  logic             reach_c;
  logic             oor_c;
  logic [WIDTH-1:0] clamp_cnt_c;
  logic [WIDTH-1:0] clamp_ld_c;

`ifdef UDC_CYCLE_COUNT_EN
  logic [7:0]       cycles_q, cycles_d;
  logic             done_q, done_d;
  logic             cyc_evt_c;
`endif

  assign mode_c    = counter_mode_t'(mode);
  assign cfg_bad_c = lo_lim > hi_lim;

`ifdef UDC_CYCLE_COUNT_EN
  assign run_c = en & ~done_q;
`else
  assign run_c = en;
`endif

  // Travel direction presented to the step ALU.
  always_comb begin
    alu_up_c = 1'b1;
    case (mode_c)
      MODE_UP_WRAP:   alu_up_c = 1'b1;
      MODE_DOWN_WRAP: alu_up_c = 1'b0;
      MODE_SATURATE:  alu_up_c = dir;
      MODE_BOUNCE:    alu_up_c = (state_q == BS_UP);
      default:        alu_up_c = 1'b1;
    endcase
  end

  udc_step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_alu (
    .count_i       (count_q),
    .step_i        (step),
    .lo_i          (lo_lim),
    .hi_i          (hi_lim),
    .load_val_i    (load_val),
    .up_i          (alu_up_c),
    .nxt_c_o       (nxt_c),
    .over_c_o      (over_c),
    .reach_c_o     (reach_c),
    .oor_c_o       (oor_c),
    .clamp_cnt_c_o (clamp_cnt_c),
    .clamp_ld_c_o  (clamp_ld_c)
  );

  // Next-state logic: invalid limits > load > enabled step > hold.
  always_comb begin
    count_d  = count_q;
    dir_up_d = dir_up_q;
    turn_d   = 1'b0;
    state_d  = state_q;
    dwell_d  = dwell_q;
`ifdef UDC_CYCLE_COUNT_EN
    cyc_evt_c = 1'b0;
`endif
    if (cfg_bad_c) begin
      // Everything frozen until the limits are valid again.
    end else if (load) begin
      count_d = clamp_ld_c;
      state_d = dir_up_q ? BS_UP : BS_DOWN;
      dwell_d = '0;
    end else if (run_c) begin
      case (mode_c)
        MODE_UP_WRAP:   dir_up_d = 1'b1;
        MODE_DOWN_WRAP: dir_up_d = 1'b0;
        MODE_SATURATE:  dir_up_d = dir;
        default:        dir_up_d = dir_up_q;
      endcase
      // Outside BOUNCE the FSM tracks dir_up so re-entry starts the right way
      // and any pending dwell is dropped.
      if (mode_c != MODE_BOUNCE) begin
        state_d = dir_up_d ? BS_UP : BS_DOWN;
        dwell_d = '0;
      end
      if (oor_c) begin
        count_d = clamp_cnt_c;
      end else if (step != '0) begin
        case (mode_c)
          MODE_UP_WRAP: begin
            if (over_c) begin
              count_d = lo_lim;
              turn_d  = 1'b1;
`ifdef UDC_CYCLE_COUNT_EN
              cyc_evt_c = 1'b1;
`endif
            end else begin
              count_d = nxt_c;
            end
          end
          MODE_DOWN_WRAP: begin
            if (over_c) begin
              count_d = hi_lim;
              turn_d  = 1'b1;
`ifdef UDC_CYCLE_COUNT_EN
              cyc_evt_c = 1'b1;
`endif
            end else begin
              count_d = nxt_c;
            end
          end
          MODE_SATURATE: begin
            if (over_c) count_d = dir ? hi_lim : lo_lim;
            else        count_d = nxt_c;
          end
          default: begin
            case (state_q)
              BS_UP: begin
                if (reach_c) begin
                  count_d = hi_lim;
                  turn_d  = 1'b1;
                  if (DWELL > 0) begin
                    state_d = BS_DWELL_HI;
                  end else begin
                    state_d  = BS_DOWN;
                    dir_up_d = 1'b0;
                  end
                end else begin
                  count_d = nxt_c;
                end
              end
              BS_DOWN: begin
                if (reach_c) begin
                  count_d = lo_lim;
                  turn_d  = 1'b1;
`ifdef UDC_CYCLE_COUNT_EN
                  cyc_evt_c = 1'b1;
`endif
                  if (DWELL > 0) begin
                    state_d = BS_DWELL_LO;
                  end else begin
                    state_d  = BS_UP;
                    dir_up_d = 1'b1;
                  end
                end else begin
                  count_d = nxt_c;
                end
              end
              BS_DWELL_HI: begin
                if (dwell_q == DWELL_LAST) begin
                  state_d  = BS_DOWN;
                  dir_up_d = 1'b0;
                  dwell_d  = '0;
                end else begin
                  dwell_d = dwell_q + DW_W'(1);
                end
              end
              default: begin
                if (dwell_q == DWELL_LAST) begin
                  state_d  = BS_UP;
                  dir_up_d = 1'b1;
                  dwell_d  = '0;
                end else begin
                  dwell_d = dwell_q + DW_W'(1);
                end
              end
            endcase
          end
        endcase
      end
    end
  end

  // Core state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= WIDTH'(RESET_VAL);
      dir_up_q  <= 1'b1;
      turn_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      state_q   <= BS_UP;
      dwell_q   <= '0;
    end else begin
      count_q   <= count_d;
      dir_up_q  <= dir_up_d;
      turn_q    <= turn_d;
      cfg_err_q <= cfg_bad_c;
      state_q   <= state_d;
      dwell_q   <= dwell_d;
    end
  end

  assign count   = count_q;
  assign dir_up  = dir_up_q;
  assign turn    = turn_q;
  assign cfg_err = cfg_err_q;

`ifdef UDC_CYCLE_COUNT_EN
  // Completed-cycle counter; done latches until load or reset.
  always_comb begin
    cycles_d = cycles_q;
    done_d   = done_q;
    if (!cfg_bad_c && load) begin
      cycles_d = '0;
      done_d   = 1'b0;
    end else begin
      if (cyc_evt_c && (cycles_q != 8'hFF)) cycles_d = cycles_q + 8'd1;
      if ((target != 8'd0) && (cycles_d == target)) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cycles_q <= cycles_d;
      done_q   <= done_d;
    end
  end

  assign cycles = cycles_q;
  assign done   = done_q;
`endif

endmodule

// File: tb/tb_updown_bounce_counter.sv
// Self-checking bench for updown_bounce_counter: two instances (DWELL=0 and
// DWELL=2) share stimulus and are compared every cycle against a behavioural
// model, with directed scenarios followed by randomized traffic.
module tb_updown_bounce_counter;
  import arch_defs_pkg::*;

  localparam int unsigned W     = 8;
  localparam int unsigned SW    = 4;
  localparam int unsigned RST_V = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          load;
  logic [W-1:0]  load_val;
  logic [1:0]    mode;
  logic          dir;
  logic [W-1:0]  lo_lim;
  logic [W-1:0]  hi_lim;
  logic [SW-1:0] step;
  logic [W-1:0]  cnt_o  [2];
  logic          dir_o  [2];
  logic          turn_o [2];
  logic          cerr_o [2];
`ifdef UDC_CYCLE_COUNT_EN
  logic [7:0]    target;
  logic [7:0]    cyc_o  [2];
  logic          done_o [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model state: count, direction, remaining dwell cycles, pulses, cycle count.
  int m_cnt  [2];
  bit m_up   [2];
  int m_dw   [2];
  bit m_turn [2];
  bit m_cfg  [2];
  int m_cyc  [2];
  bit m_done [2];

  always #5 clk = ~clk;

  updown_bounce_counter #(
    .WIDTH(W), .STEP_W(SW), .DWELL(0), .RESET_VAL(RST_V)
  ) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .dir(dir), .lo_lim(lo_lim), .hi_lim(hi_lim), .step(step),
    .count(cnt_o[0]), .dir_up(dir_o[0]), .turn(turn_o[0]), .cfg_err(cerr_o[0])
`ifdef UDC_CYCLE_COUNT_EN
    , .target(target), .cycles(cyc_o[0]), .done(done_o[0])
`endif
  );

  updown_bounce_counter #(
    .WIDTH(W), .STEP_W(SW), .DWELL(2), .RESET_VAL(RST_V)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
    .mode(mode), .dir(dir), .lo_lim(lo_lim), .hi_lim(hi_lim), .step(step),
    .count(cnt_o[1]), .dir_up(dir_o[1]), .turn(turn_o[1]), .cfg_err(cerr_o[1])
`ifdef UDC_CYCLE_COUNT_EN
    , .target(target), .cycles(cyc_o[1]), .done(done_o[1])
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dwell_of(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int clampv(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = RST_V;
      m_up[i]   = 1'b1;
      m_dw[i]   = 0;
      m_turn[i] = 1'b0;
      m_cfg[i]  = 1'b0;
      m_cyc[i]  = 0;
      m_done[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference behaviour, using plain integer arithmetic.
  task automatic model_step();
    int lo, hi, st, c;
    bit evt, cleared;
    lo = int'(lo_lim);
    hi = int'(hi_lim);
    st = int'(step);
    for (int i = 0; i < 2; i++) begin
      evt = 1'b0;
      cleared = 1'b0;
      m_turn[i] = 1'b0;
      m_cfg[i]  = (lo > hi);
      c = m_cnt[i];
      if (lo > hi) begin
        c = m_cnt[i];
      end else if (load) begin
        c = clampv(int'(load_val), lo, hi);
        m_dw[i] = 0;
        m_cyc[i] = 0;
        m_done[i] = 1'b0;
        cleared = 1'b1;
      end else if (en && !m_done[i]) begin
        if (mode != 2'd3) begin
          m_dw[i] = 0;
          m_up[i] = (mode == 2'd0) ? 1'b1 : (mode == 2'd1) ? 1'b0 : dir;
        end
        if (c < lo || c > hi) begin
          c = clampv(c, lo, hi);
        end else if (st != 0) begin
          case (mode)
            2'd0: if (c + st > hi) begin c = lo; m_turn[i] = 1'b1; evt = 1'b1; end
                  else c = c + st;
            2'd1: if (c - st < lo) begin c = hi; m_turn[i] = 1'b1; evt = 1'b1; end
                  else c = c - st;
            2'd2: c = dir ? ((c + st > hi) ? hi : c + st) : ((c - st < lo) ? lo : c - st);
            default: begin
              if (m_dw[i] > 0) begin
                m_dw[i]--;
                if (m_dw[i] == 0) m_up[i] = !m_up[i];
              end else if (m_up[i]) begin
                if (c + st >= hi) begin
                  c = hi;
                  m_turn[i] = 1'b1;
                  if (dwell_of(i) > 0) m_dw[i] = dwell_of(i);
                  else m_up[i] = 1'b0;
                end else c = c + st;
              end else begin
                if (c - st <= lo) begin
                  c = lo;
                  m_turn[i] = 1'b1;
                  evt = 1'b1;
                  if (dwell_of(i) > 0) m_dw[i] = dwell_of(i);
                  else m_up[i] = 1'b1;
                end else c = c - st;
              end
            end
          endcase
        end
      end
      if (evt && m_cyc[i] < 255) m_cyc[i]++;
`ifdef UDC_CYCLE_COUNT_EN
      if (!cleared && target != 8'd0 && m_cyc[i] == int'(target)) m_done[i] = 1'b1;
`else
      if (cleared) m_cyc[i] = 0;
`endif
      m_cnt[i] = c;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.count", i),   int'(cnt_o[i]),  m_cnt[i]);
      chk($sformatf("d%0d.dir_up", i),  int'(dir_o[i]),  int'(m_up[i]));
      chk($sformatf("d%0d.turn", i),    int'(turn_o[i]), int'(m_turn[i]));
      chk($sformatf("d%0d.cfg_err", i), int'(cerr_o[i]), int'(m_cfg[i]));
`ifdef UDC_CYCLE_COUNT_EN
      chk($sformatf("d%0d.cycles", i),  int'(cyc_o[i]),  m_cyc[i]);
      chk($sformatf("d%0d.done", i),    int'(done_o[i]), int'(m_done[i]));
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges; values must change at once.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d.rst_count", i), int'(cnt_o[i]), int'(RST_V));
      chk($sformatf("d%0d.rst_dir", i),   int'(dir_o[i]),  1);
      chk($sformatf("d%0d.rst_turn", i),  int'(turn_o[i]), 0);
      chk($sformatf("d%0d.rst_cerr", i),  int'(cerr_o[i]), 0);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    int e1 [11];
    int e5 [7];
    int k, a, b;

    e1 = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
    e5 = '{1, 2, 3, 4, 4, 4, 3};

    reset = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; mode = 2'd0;
    dir = 1'b1; lo_lim = '0; hi_lim = 8'd255; step = 4'd1;
`ifdef UDC_CYCLE_COUNT_EN
    target = 8'd0;
`endif
    do_reset();

    // Bounce 0..5 with no dwell.
    mode = 2'd3; lo_lim = 8'd0; hi_lim = 8'd5; step = 4'd1; en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("s1.count", int'(cnt_o[0]), e1[i]);
      chk("s1.turn", int'(turn_o[0]), (i == 4 || i == 9) ? 1 : 0);
    end

    // Up-wrap from a load near the top.
    mode = 2'd0; lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd4;
    en = 1'b0; load = 1'b1; load_val = 8'd18;
    tick();
    chk("s2.load", int'(cnt_o[0]), 18);
    load = 1'b0; en = 1'b1;
    tick();
    chk("s2.wrap", int'(cnt_o[0]), 10);
    chk("s2.turn", int'(turn_o[0]), 1);
    tick();
    chk("s2.c14", int'(cnt_o[0]), 14);
    tick();
    chk("s2.c18", int'(cnt_o[0]), 18);

    // Saturate at the upper limit, then step down.
    mode = 2'd2; dir = 1'b1; lo_lim = 8'd0; hi_lim = 8'd200; step = 4'd15;
    en = 1'b0; load = 1'b1; load_val = 8'd190;
    tick();
    chk("s3.load", int'(cnt_o[0]), 190);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s3.sat", int'(cnt_o[0]), 200);
      chk("s3.turn", int'(turn_o[0]), 0);
    end
    dir = 1'b0;
    tick();
    chk("s3.down", int'(cnt_o[0]), 185);

    // Invalid limits freeze the counter; load and en ignored.
    mode = 2'd0; dir = 1'b1; lo_lim = 8'd0; hi_lim = 8'd50; step = 4'd1;
    tick();
    chk("s4.clamp", int'(cnt_o[0]), 50);
    tick();
    tick();
    chk("s4.pre", int'(cnt_o[0]), 1);
    lo_lim = 8'd9; hi_lim = 8'd3;
    tick();
    chk("s4.cerr", int'(cerr_o[0]), 1);
    chk("s4.frz", int'(cnt_o[0]), 1);
    load = 1'b1; load_val = 8'd7;
    tick();
    chk("s4.frz_ld", int'(cnt_o[0]), 1);
    load = 1'b0;
    tick();
    chk("s4.frz_en", int'(cnt_o[0]), 1);
    lo_lim = 8'd0; hi_lim = 8'd50;
    tick();
    chk("s4.resume", int'(cnt_o[0]), 2);
    chk("s4.cerr_clr", int'(cerr_o[0]), 0);

    // Bounce with dwell on instance 1, enable toggled every other cycle.
    do_reset();
    mode = 2'd3; lo_lim = 8'd0; hi_lim = 8'd4; step = 4'd1;
    k = 0;
    for (int i = 0; i < 14; i++) begin
      en = (i % 2 == 0);
      tick();
      if (en) begin
        chk("s5.dwell", int'(cnt_o[1]), e5[k]);
        k++;
      end
    end
    do_reset();
    en = 1'b1;
    repeat (5) tick();
    chk("s5.mid_dwell", int'(cnt_o[1]), 4);
    do_reset();
    chk("s5.rst_cnt", int'(cnt_o[1]), int'(RST_V));
    chk("s5.rst_dir", int'(dir_o[1]), 1);

`ifdef UDC_CYCLE_COUNT_EN
    // Stop after two complete bounce cycles.
    do_reset();
    target = 8'd2; mode = 2'd3; lo_lim = 8'd0; hi_lim = 8'd3; step = 4'd1; en = 1'b1;
    repeat (12) tick();
    chk("s6.count", int'(cnt_o[0]), 0);
    chk("s6.cycles", int'(cyc_o[0]), 2);
    chk("s6.done", int'(done_o[0]), 1);
    repeat (3) tick();
    chk("s6.stopped", int'(cnt_o[0]), 0);
    en = 1'b0; load = 1'b1; load_val = 8'd1;
    tick();
    chk("s6.ld_cnt", int'(cnt_o[0]), 1);
    chk("s6.ld_cyc", int'(cyc_o[0]), 0);
    chk("s6.ld_done", int'(done_o[0]), 0);
    load = 1'b0; target = 8'd0;
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        a = $urandom_range(0, 255);
        case ($urandom_range(0, 3))
          0:       b = a + $urandom_range(0, 12);
          1:       b = a;
          2:       b = $urandom_range(0, 255);
          default: b = a + $urandom_range(0, 40);
        endcase
        if (b > 255) b = 255;
        lo_lim = W'(a);
        hi_lim = W'(b);
      end
      if ($urandom_range(0, 29) == 0) step = SW'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      load = ($urandom_range(0, 24) == 0);
      load_val = W'($urandom_range(0, 255));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
